// File: rtl/t03_mem_sequencer.sv
// t03_mem_sequencer: multicycle fetch/load/store sequencer on one memory bus (optional T03_PERF_CNT_EN perf counters)
module t03_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_FETCH_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  dataWidth,
  input  logic [31:0] data_addr,
  input  logic [31:0] store_data,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        commit,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
`ifdef T03_PERF_CNT_EN
  ,
  output logic [31:0] instret_cnt,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic [2:0] {WAIT, FETCH, EXEC, DATA, WB, FAULT} state_t;
  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic [15:0] tcnt_q;
  logic [31:0] instr_q, load_q;
  logic [1:0]  fc_q;
  logic        is_mem, bad_w, mis, tmo, fetch_s, data_s;
  logic [31:0] sh, ld_d, wdata_d;
  logic [3:0]  sel_d;
  assign is_mem  = memRead | memWrite;
  assign bad_w   = dataWidth[1:0] == 2'b11 || (dataWidth[2] && dataWidth[1]);
  assign mis     = (dataWidth[1:0] == 2'b01 && data_addr[0]) || (dataWidth[1:0] == 2'b10 && data_addr[1:0] != 2'b00);
  assign tmo     = tcnt_q == 16'(TIMEOUT_CYCLES - 1);
  assign fetch_s = !rst && state_q == FETCH;
  assign data_s  = !rst && state_q == DATA;
  assign sh      = bus_rdata >> {data_addr[1:0], 3'b000};
  assign ld_d    = dataWidth[1:0] == 2'b00 ? {{24{~dataWidth[2] & sh[7]}}, sh[7:0]}
                 : dataWidth[1:0] == 2'b01 ? {{16{~dataWidth[2] & sh[15]}}, sh[15:0]} : bus_rdata;
  assign sel_d   = dataWidth[1:0] == 2'b00 ? 4'b0001 << data_addr[1:0]
                 : dataWidth[1:0] == 2'b01 ? (data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = dataWidth[1:0] == 2'b00 ? {4{store_data[7:0]}}
                 : dataWidth[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  assign bus_ren    = fetch_s || (data_s && memRead);
  assign bus_wen    = data_s && memWrite && !memRead;
  assign bus_addr   = fetch_s ? {pc[31:2], 2'b00} : data_s ? {data_addr[31:2], 2'b00} : 32'h0;
  assign bus_sel    = fetch_s ? 4'b1111 : data_s ? sel_d : 4'b0000;
  assign bus_wdata  = bus_wen ? wdata_d : 32'h0;
  assign commit     = !rst && (state_q == WB || (state_q == EXEC && !is_mem));
  assign fault      = !rst && state_q == FAULT;
  assign fault_code = rst ? 2'b00 : fc_q;
  assign instr      = rst ? 32'h0 : instr_q;
  assign load_data  = rst ? 32'h0 : load_q;
  // sequencer FSM: wait, fetch, decode check, data access, writeback, halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      instr_q <= '0;
      load_q  <= '0;
      fc_q    <= '0;
    end else begin
      case (state_q)
        WAIT:
          if (wcnt_q == 4'(RESET_FETCH_DELAY)) begin
            state_q <= FETCH;
            tcnt_q  <= '0;
          end else wcnt_q <= wcnt_q + 4'd1;
        FETCH:
          if (bus_ack) begin
            instr_q <= bus_rdata;
            state_q <= EXEC;
          end else if (tmo) begin
            state_q <= FAULT;
            fc_q    <= 2'b11;
          end else tcnt_q <= tcnt_q + 16'd1;
        EXEC: begin
          tcnt_q <= '0;
          if ((memRead && memWrite) || (is_mem && bad_w)) begin
            state_q <= FAULT;
            fc_q    <= 2'b10;
          end else if (!is_mem) state_q <= FETCH;
          else if (mis) begin
            state_q <= FAULT;
            fc_q    <= 2'b01;
          end else state_q <= DATA;
        end
        DATA:
          if (bus_ack) begin
            if (memRead) load_q <= ld_d;
            state_q <= WB;
          end else if (tmo) begin
            state_q <= FAULT;
            fc_q    <= 2'b11;
          end else tcnt_q <= tcnt_q + 16'd1;
        WB: begin
          state_q <= FETCH;
          tcnt_q  <= '0;
        end
        default: state_q <= FAULT;
      endcase
    end
  end
`ifdef T03_PERF_CNT_EN
  // retired-instruction and bus-stall counters, naturally frozen in FAULT
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      instret_cnt <= instret_cnt + {31'd0, commit};
      stall_cnt   <= stall_cnt + {31'd0, (fetch_s || data_s) && !bus_ack};
    end
  end
`endif
endmodule

// File: tb/tb_t03_mem_sequencer.sv
// tb_t03_mem_sequencer: table-driven plus corner-case checks of the memory sequencer
module tb_t03_mem_sequencer;
  logic        clk = 0, rst = 1;
  logic [31:0] pc = 32'h100, data_addr = 0, store_data = 0, bus_rdata = 0;
  logic        memRead = 0, memWrite = 0, bus_ack = 0;
  logic [2:0]  dataWidth = 0;
  logic [31:0] instr, load_data, bus_addr, bus_wdata;
  logic        commit, fault, bus_ren, bus_wen;
  logic [1:0]  fault_code;
  logic [3:0]  bus_sel;
`ifdef T03_PERF_CNT_EN
  logic [31:0] instret_cnt, stall_cnt;
`endif
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    logic        mr, mw;
    logic [2:0]  dw;
    logic [31:0] iw, addr, sd, rd, e_addr, e_wdata, e_load;
    logic [3:0]  e_sel;
  } vec_t;
  vec_t tbl[10];

  t03_mem_sequencer #(.TIMEOUT_CYCLES(4), .RESET_FETCH_DELAY(1)) dut (
    .clk(clk), .rst(rst), .pc(pc), .memRead(memRead), .memWrite(memWrite),
    .dataWidth(dataWidth), .data_addr(data_addr), .store_data(store_data),
    .instr(instr), .load_data(load_data), .commit(commit), .fault(fault),
    .fault_code(fault_code), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_ren(bus_ren), .bus_wen(bus_wen),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
`ifdef T03_PERF_CNT_EN
    , .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) chk({name, "_sb_empty"}, 32'd0, 32'd1);
    else chk(name, act, exp_q.pop_front());
  endtask

  task automatic reset_seq();
    rst = 1;
    bus_ack = 0;
    memRead = 0;
    memWrite = 0;
    pc = 32'h100;
    @(negedge clk);
    chk("rst_ren", {31'd0, bus_ren}, 0);
    chk("rst_wen", {31'd0, bus_wen}, 0);
    step();
    chk("rst_outs", {bus_addr | bus_wdata | instr | load_data}, 0);
    chk("rst_ctl", {26'd0, bus_sel, commit, fault}, 0);
`ifdef T03_PERF_CNT_EN
    chk("rst_instret", instret_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
`endif
    rst = 0;
    step();
    chk("wait_ren", {31'd0, bus_ren}, 0);
    step();
  endtask

  task automatic do_fetch(input logic [31:0] iw, input int waits);
    for (int w = 0; w < waits; w++) begin
      chk("fetch_wait_ren", {31'd0, bus_ren}, 1);
      step();
    end
    chk("fetch_ren", {31'd0, bus_ren}, 1);
    chk("fetch_addr", bus_addr, pc);
    chk("fetch_sel", {28'd0, bus_sel}, 32'hF);
    exp_q.push_back(iw);
    bus_ack = 1;
    bus_rdata = iw;
    step();
    bus_ack = 0;
    bus_rdata = 0;
    pop_chk("instr", instr);
  endtask

  task automatic run_vec(input vec_t v);
    memRead = v.mr;
    memWrite = v.mw;
    dataWidth = v.dw;
    data_addr = v.addr;
    store_data = v.sd;
    do_fetch(v.iw, 0);
    if (!v.mr && !v.mw) begin
      chk("exec_commit", {31'd0, commit}, 1);
      pc += 4;
      step();
      return;
    end
    chk("exec_nocommit", {31'd0, commit}, 0);
    step();
    chk("data_ren", {31'd0, bus_ren}, {31'd0, v.mr});
    chk("data_wen", {31'd0, bus_wen}, {31'd0, v.mw});
    chk("data_addr", bus_addr, v.e_addr);
    chk("data_sel", {28'd0, bus_sel}, {28'd0, v.e_sel});
    chk("data_wdata", bus_wdata, v.e_wdata);
    exp_q.push_back(v.e_load);
    bus_ack = 1;
    bus_rdata = v.rd;
    step();
    bus_ack = 0;
    bus_rdata = 0;
    chk("wb_commit", {31'd0, commit}, 1);
    pop_chk("load_data", load_data);
    pc += 4;
    step();
    chk("after_wb_commit", {31'd0, commit}, 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 3'b000, 32'h00A00093, 32'h0,   32'h0,        32'h0,        32'h0,   32'h0,        32'h0,        4'b0000};
    tbl[1] = '{1, 0, 3'b000, 32'h20300083, 32'h203, 32'h0,        32'h80FF1234, 32'h200, 32'h0,        32'hFFFFFF80, 4'b1000};
    tbl[2] = '{1, 0, 3'b100, 32'h20304083, 32'h203, 32'h0,        32'h80FF1234, 32'h200, 32'h0,        32'h00000080, 4'b1000};
    tbl[3] = '{0, 1, 3'b001, 32'h04201123, 32'h42,  32'hDEADBEEF, 32'h0,        32'h40,  32'hBEEFBEEF, 32'h00000080, 4'b1100};
    tbl[4] = '{1, 0, 3'b001, 32'h30201083, 32'h302, 32'h0,        32'h80017FFF, 32'h300, 32'h0,        32'hFFFF8001, 4'b1100};
    tbl[5] = '{1, 0, 3'b101, 32'h30005083, 32'h300, 32'h0,        32'h12348001, 32'h300, 32'h0,        32'h00008001, 4'b0011};
    tbl[6] = '{1, 0, 3'b010, 32'h40402083, 32'h404, 32'h0,        32'hCAFEF00D, 32'h404, 32'h0,        32'hCAFEF00D, 4'b1111};
    tbl[7] = '{0, 1, 3'b000, 32'h00A008A3, 32'h11,  32'h000000A5, 32'h0,        32'h10,  32'hA5A5A5A5, 32'hCAFEF00D, 4'b0010};
    tbl[8] = '{0, 1, 3'b010, 32'h02A02023, 32'h20,  32'h12345678, 32'h0,        32'h20,  32'h12345678, 32'hCAFEF00D, 4'b1111};
    tbl[9] = '{1, 0, 3'b000, 32'h50000083, 32'h500, 32'h0,        32'h0000007F, 32'h500, 32'h0,        32'h0000007F, 4'b0001};
    reset_seq();
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    chk("no_fault", {31'd0, fault}, 0);
    memRead = 1;
    memWrite = 0;
    dataWidth = 3'b010;
    data_addr = 32'h6;
    do_fetch(32'h00602083, 0);
    chk("mis_nocommit", {31'd0, commit}, 0);
    step();
    chk("mis_fault", {31'd0, fault}, 1);
    chk("mis_code", {30'd0, fault_code}, 1);
    for (int i = 0; i < 3; i++) begin
      chk("mis_idle", {29'd0, bus_ren, bus_wen, commit}, 0);
      step();
    end
    chk("mis_sticky", {29'd0, fault, fault_code}, 3'b101);
    reset_seq();
    memRead = 1;
    dataWidth = 3'b011;
    data_addr = 32'h0;
    do_fetch(32'h00003083, 0);
    chk("ill_nocommit", {31'd0, commit}, 0);
    step();
    chk("ill_fault", {29'd0, fault, fault_code}, 3'b110);
    chk("ill_idle", {30'd0, bus_ren, bus_wen}, 0);
    reset_seq();
    memRead = 0;
    do_fetch(32'h00100113, 3);
    chk("late_ack_commit", {31'd0, commit}, 1);
    chk("late_ack_nofault", {31'd0, fault}, 0);
    pc += 4;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("tmo_ren", {31'd0, bus_ren}, 1);
      step();
    end
    chk("tmo_fault", {29'd0, fault, fault_code}, 3'b111);
    chk("tmo_drop", {30'd0, bus_ren, bus_wen}, 0);
    reset_seq();
    memWrite = 1;
    dataWidth = 3'b010;
    data_addr = 32'h80;
    store_data = 32'h55AA55AA;
    do_fetch(32'h08A02023, 0);
    step();
    chk("rstdata_wen", {31'd0, bus_wen}, 1);
    step();
    chk("rstdata_wen_wait", {31'd0, bus_wen}, 1);
    reset_seq();
    chk("rstdata_nocommit", {31'd0, commit}, 0);
    chk("restart_fetch", {31'd0, bus_ren}, 1);
    chk("restart_wen", {31'd0, bus_wen}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
